// File: rtl/move_scheduler.sv
// Arbitrates latched move commands and gravity onto a single-outstanding action
// channel, sequences hard drops as DOWN steps ending in LOCK, and holds off input until spawn.
module move_scheduler #(
  parameter int MAX_DROP_STEPS = 24,
  parameter int DW             = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          game_active,
  input  logic          cmd_left,
  input  logic          cmd_right,
  input  logic          cmd_down,
  input  logic          cmd_rotate,
  input  logic          cmd_drop,
  input  logic          tick_gravity,
  input  logic          piece_spawned,
  output logic          act_valid,
  output logic [2:0]    act_code,
  input  logic          act_ready,
  input  logic          resp_valid,
  input  logic          resp_ok,
  output logic [DW-1:0] drop_rows,
  output logic          drop_done,
  output logic [7:0]    missed_gravity
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DROP_REQ, S_DROP_WAIT, S_LOCK_REQ, S_LOCKOUT
  } state_e;

  localparam logic [2:0] A_LEFT = 3'd1, A_RIGHT = 3'd2, A_DOWN = 3'd3,
                         A_ROT  = 3'd4, A_LOCK  = 3'd5;
  localparam int P_GRAV = 0, P_DOWN = 1, P_RIGHT = 2, P_LEFT = 3, P_ROT = 4, P_DROP = 5;
  localparam logic [DW-1:0] STEP_LIMIT = DW'(MAX_DROP_STEPS);

  state_e        state_q, state_d;
  logic          act_valid_q, act_valid_d;
  logic [2:0]    act_code_q, act_code_d;
  logic          grav_tag_q, grav_tag_d;
  logic          from_drop_q, from_drop_d;
  logic [DW-1:0] steps_q, steps_d, steps_inc;
  logic [DW-1:0] drop_rows_q, drop_rows_d;
  logic [7:0]    missed_q, missed_d;
  logic [5:0]    pend_q, pend_d, pend_set, pend_clr;
  logic          accept;

  assign pend_set  = {cmd_drop, cmd_rotate, cmd_left, cmd_right, cmd_down, tick_gravity};
  assign accept    = act_valid_q & act_ready;
  assign steps_inc = steps_q + 1'b1;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    act_valid_d = act_valid_q;
    act_code_d  = act_code_q;
    grav_tag_d  = grav_tag_q;
    from_drop_d = from_drop_q;
    steps_d     = steps_q;
    drop_rows_d = drop_rows_q;
    pend_clr    = '0;
    drop_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q[P_DROP]) begin
          state_d          = S_DROP_REQ;
          act_valid_d      = 1'b1;
          act_code_d       = A_DOWN;
          pend_clr[P_DROP] = 1'b1;
          steps_d          = '0;
          from_drop_d      = 1'b1;
        end else if (pend_q[P_ROT]) begin
          state_d     = S_REQ;
          act_valid_d = 1'b1;
          act_code_d  = A_ROT;
        end else begin
          // Opposing left/right cancel each other and fall through to DOWN/gravity.
          if (pend_q[P_LEFT] && pend_q[P_RIGHT]) begin
            pend_clr[P_LEFT]  = 1'b1;
            pend_clr[P_RIGHT] = 1'b1;
          end
          if (pend_q[P_LEFT] ^ pend_q[P_RIGHT]) begin
            state_d     = S_REQ;
            act_valid_d = 1'b1;
            act_code_d  = pend_q[P_LEFT] ? A_LEFT : A_RIGHT;
          end else if (pend_q[P_DOWN] || pend_q[P_GRAV]) begin
            state_d     = S_REQ;
            act_valid_d = 1'b1;
            act_code_d  = A_DOWN;
            grav_tag_d  = pend_q[P_GRAV];
            from_drop_d = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (accept) begin
          state_d     = S_WAIT;
          act_valid_d = 1'b0;
          unique case (act_code_q)
            A_LEFT:  pend_clr[P_LEFT]  = 1'b1;
            A_RIGHT: pend_clr[P_RIGHT] = 1'b1;
            A_ROT:   pend_clr[P_ROT]   = 1'b1;
            A_DOWN: begin
              pend_clr[P_DOWN] = 1'b1;
              pend_clr[P_GRAV] = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          if (act_code_q == A_DOWN && grav_tag_q && !resp_ok) begin
            state_d     = S_LOCK_REQ;
            act_valid_d = 1'b1;
            act_code_d  = A_LOCK;
            from_drop_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP_REQ: begin
        if (accept) begin
          state_d     = S_DROP_WAIT;
          act_valid_d = 1'b0;
        end
      end
      S_DROP_WAIT: begin
        if (resp_valid) begin
          act_valid_d = 1'b1;
          if (resp_ok) steps_d = steps_inc;
          if (!resp_ok || steps_inc == STEP_LIMIT) begin
            state_d    = S_LOCK_REQ;
            act_code_d = A_LOCK;
          end else begin
            state_d    = S_DROP_REQ;
            act_code_d = A_DOWN;
          end
        end
      end
      S_LOCK_REQ: begin
        if (accept) begin
          state_d     = S_LOCKOUT;
          act_valid_d = 1'b0;
          pend_clr    = '1;
          if (from_drop_q) begin
            drop_rows_d = steps_q;
            drop_done   = 1'b1;
          end
        end
      end
      S_LOCKOUT: begin
        if (piece_spawned) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!game_active) begin
      state_d     = S_IDLE;
      act_valid_d = 1'b0;
      drop_rows_d = drop_rows_q;
      drop_done   = 1'b0;
    end
  end

  // A new pulse wins over a same-cycle clear, so a fresh request is never lost.
  always_comb begin
    pend_d = '0;
    if (game_active)
      pend_d = (pend_q & ~pend_clr) | ((state_q == S_LOCKOUT) ? 6'b0 : pend_set);
  end

  always_comb begin
    missed_d = missed_q;
    if (game_active && state_q != S_LOCKOUT && tick_gravity && pend_q[P_GRAV] && missed_q != 8'hFF)
      missed_d = missed_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      act_valid_q <= 1'b0;
      act_code_q  <= '0;
      grav_tag_q  <= 1'b0;
      from_drop_q <= 1'b0;
      steps_q     <= '0;
      drop_rows_q <= '0;
      missed_q    <= '0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      act_valid_q <= act_valid_d;
      act_code_q  <= act_code_d;
      grav_tag_q  <= grav_tag_d;
      from_drop_q <= from_drop_d;
      steps_q     <= steps_d;
      drop_rows_q <= drop_rows_d;
      missed_q    <= missed_d;
      pend_q      <= pend_d;
    end
  end

  assign act_valid      = act_valid_q;
  assign act_code       = act_code_q;
  assign drop_rows      = drop_rows_q;
  assign missed_gravity = missed_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: plays the collision checker and checks
// issued actions, latency, hard-drop sequencing, lockout, stall and abort behaviour.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       rst, game_active;
  logic       cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop, tick_gravity, piece_spawned;
  logic       act_valid, act_ready, resp_valid, resp_ok, drop_done;
  logic [2:0] act_code;
  logic [4:0] drop_rows;
  logic [7:0] missed_gravity;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer [8];
  int n_dd = 0;

  localparam logic [6:0] M_DROP = 7'b1000000, M_ROT  = 7'b0100000, M_LEFT  = 7'b0010000,
                         M_RIGHT = 7'b0001000, M_GRAV = 7'b0000010, M_SPAWN = 7'b0000001;

  always #5 clk = ~clk;

  move_scheduler #(.MAX_DROP_STEPS(24), .DW(5)) dut (
    .clk(clk), .rst(rst), .game_active(game_active),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_down(cmd_down),
    .cmd_rotate(cmd_rotate), .cmd_drop(cmd_drop), .tick_gravity(tick_gravity),
    .piece_spawned(piece_spawned),
    .act_valid(act_valid), .act_code(act_code), .act_ready(act_ready),
    .resp_valid(resp_valid), .resp_ok(resp_ok),
    .drop_rows(drop_rows), .drop_done(drop_done), .missed_gravity(missed_gravity)
  );

  // Transfer and drop_done log, sampled mid-cycle.
  initial for (int i = 0; i < 8; i++) n_xfer[i] = 0;
  always @(negedge clk) begin
    if (!rst && act_valid && act_ready) n_xfer[act_code] = n_xfer[act_code] + 1;
    if (!rst && drop_done) n_dd = n_dd + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [6:0] m);
    {cmd_drop, cmd_rotate, cmd_left, cmd_right, cmd_down, tick_gravity, piece_spawned} = m;
    step();
    {cmd_drop, cmd_rotate, cmd_left, cmd_right, cmd_down, tick_gravity, piece_spawned} = '0;
  endtask

  // Waits for a request, lets it transfer (act_ready assumed high), then optionally answers.
  task automatic serve(input logic ok, input int lat, input logic respond, output logic [2:0] code);
    int n = 0;
    while (act_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("act_valid_wait", act_valid, 1'b1);
    code = act_code;
    step();
    if (respond) begin
      repeat (lat - 1) step();
      resp_valid = 1'b1;
      resp_ok    = ok;
      step();
      resp_valid = 1'b0;
      resp_ok    = 1'b0;
    end
  endtask

  function automatic int total_xfers();
    int s = 0;
    for (int i = 0; i < 8; i++) s += n_xfer[i];
    return s;
  endfunction

  initial begin
    logic [2:0] code;
    int t0, d0, l0;

    rst = 1'b1; game_active = 1'b1; act_ready = 1'b1; resp_valid = 1'b0; resp_ok = 1'b0;
    {cmd_drop, cmd_rotate, cmd_left, cmd_right, cmd_down, tick_gravity, piece_spawned} = '0;
    repeat (3) step();
    check("rst_act_valid", act_valid, 0);
    check("rst_act_code", act_code, 0);
    check("rst_drop_rows", drop_rows, 0);
    check("rst_drop_done", drop_done, 0);
    check("rst_missed", missed_gravity, 0);
    rst = 1'b0;
    repeat (2) step();

    // Single rotate: valid at N+2, exactly one ROTATE transfer.
    t0 = total_xfers();
    pulse(M_ROT);
    check("rot_valid_n1", act_valid, 0);
    step();
    check("rot_valid_n2", act_valid, 1);
    check("rot_code", act_code, 4);
    serve(1'b1, 2, 1'b1, code);
    check("rot_served", code, 4);
    repeat (5) step();
    check("rot_one_xfer", total_xfers() - t0, 1);
    check("rot_count", n_xfer[4], 1);

    // Left+right cancel; only rotate is issued.
    t0 = total_xfers();
    pulse(M_LEFT | M_RIGHT | M_ROT);
    serve(1'b1, 1, 1'b1, code);
    check("lr_rot_code", code, 4);
    repeat (10) step();
    check("lr_only_rot", total_xfers() - t0, 1);
    check("lr_no_lr", n_xfer[1] + n_xfer[2], 0);

    // Gravity blocked -> LOCK; lockout ignores left until spawn.
    pulse(M_GRAV);
    serve(1'b0, 1, 1'b1, code);
    check("grav_down", code, 3);
    serve(1'b0, 1, 1'b0, code);
    check("grav_lock", code, 5);
    check("grav_lock_no_dd", n_dd, 0);
    t0 = total_xfers();
    pulse(M_LEFT);
    repeat (6) step();
    check("lockout_idle", act_valid, 0);
    check("lockout_no_xfer", total_xfers() - t0, 0);
    pulse(M_SPAWN);
    pulse(M_LEFT);
    serve(1'b1, 1, 1'b1, code);
    check("spawn_left", code, 1);
    check("grav_drop_rows", drop_rows, 0);

    // Hard drop: 5 ok then blocked -> 6 DOWN + LOCK, drop_rows=5.
    d0 = n_xfer[3]; l0 = n_xfer[5];
    pulse(M_DROP);
    for (int i = 0; i < 6; i++) begin
      serve(i < 5, 1, 1'b1, code);
      check("drop5_down", code, 3);
    end
    serve(1'b0, 1, 1'b0, code);
    check("drop5_lock", code, 5);
    step();
    check("drop5_downs", n_xfer[3] - d0, 6);
    check("drop5_locks", n_xfer[5] - l0, 1);
    check("drop5_rows", drop_rows, 5);
    check("drop5_dd_cycles", n_dd, 1);
    pulse(M_SPAWN);

    // Hard drop always ok -> 24 DOWN then forced LOCK.
    d0 = n_xfer[3];
    pulse(M_DROP);
    for (int i = 0; i < 24; i++) serve(1'b1, 1, 1'b1, code);
    serve(1'b0, 1, 1'b0, code);
    check("drop24_lock", code, 5);
    step();
    check("drop24_downs", n_xfer[3] - d0, 24);
    check("drop24_rows", drop_rows, 24);
    check("drop24_dd_cycles", n_dd, 2);
    pulse(M_SPAWN);

    // Stalled request: code stable, two merged gravity ticks counted.
    act_ready = 1'b0;
    d0 = n_xfer[3];
    pulse(M_GRAV);
    step();
    for (int i = 0; i < 10; i++) begin
      tick_gravity = (i == 3 || i == 6);
      step();
      tick_gravity = 1'b0;
      check("stall_valid", act_valid, 1);
      check("stall_code", act_code, 3);
    end
    check("stall_missed", missed_gravity, 2);
    act_ready = 1'b1;
    step();
    resp_valid = 1'b1; resp_ok = 1'b1;
    step();
    resp_valid = 1'b0; resp_ok = 1'b0;
    repeat (5) step();
    check("stall_one_down", n_xfer[3] - d0, 1);

    // game_active low mid-request aborts and drops pending work.
    act_ready = 1'b0;
    t0 = total_xfers();
    pulse(M_ROT);
    step();
    check("abort_pre_valid", act_valid, 1);
    game_active = 1'b0;
    step();
    check("abort_valid", act_valid, 0);
    game_active = 1'b1;
    act_ready = 1'b1;
    repeat (4) step();
    check("abort_no_reissue", act_valid, 0);
    check("abort_no_xfer", total_xfers() - t0, 0);

    // Async reset mid-drop clears outputs immediately.
    pulse(M_DROP);
    serve(1'b1, 1, 1'b1, code);
    serve(1'b1, 1, 1'b1, code);
    check("mid_drop_valid", act_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", act_valid, 0);
    check("arst_code", act_code, 0);
    check("arst_rows", drop_rows, 0);
    check("arst_missed", missed_gravity, 0);
    check("arst_dd", drop_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
